// File: rtl/usart_tx.sv
// 8N1 asynchronous serial transmitter, LSB first, one byte per send strobe.
// Define USART_PARITY_EN to insert an even-parity bit between data and stop.
module usart_tx #(
  parameter int fsm_clk_freq = 16000000,
  parameter int baud_rate    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx_led,
  input  logic [7:0] bytetosend,
  input  logic       send,
  output logic       sent,
  output logic       tx
);

  localparam int DIV = fsm_clk_freq / baud_rate;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("usart_tx: fsm_clk_freq/baud_rate must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef USART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, sent_n, led_n;
  logic          baud_last;

  assign baud_last = (baud_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      sent     <= 1'b1;
      tx_led   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      sent     <= sent_n;
      tx_led   <= led_n;
    end
  end

  // Outputs are computed one cycle ahead so tx/sent/tx_led come straight from flops.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    idx_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx;
    sent_n  = sent;
    led_n   = tx_led;
    if (state != S_IDLE)
      baud_n = baud_last ? '0 : baud_cnt + 1'b1;
    case (state)
      S_IDLE: begin
        if (send) begin
          state_n = S_START;
          shreg_n = bytetosend;
          baud_n  = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          sent_n  = 1'b0;
          led_n   = 1'b1;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_n = S_DATA;
          idx_n   = '0;
          tx_n    = shreg[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
`ifdef USART_PARITY_EN
            state_n = S_PARITY;
            tx_n    = ^shreg;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = bit_idx + 3'd1;
            tx_n  = shreg[bit_idx + 3'd1];
          end
        end
      end
`ifdef USART_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          state_n = S_IDLE;
          tx_n    = 1'b1;
          sent_n  = 1'b1;
          led_n   = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
        sent_n  = 1'b1;
        led_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usart_tx.sv
// Directed bench for usart_tx at default clocking (DIV=138); follows USART_PARITY_EN.
module tb_usart_tx;

  localparam int DIV = 138;
`ifdef USART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic [7:0] bytetosend = 8'h00;
  logic       tx_led, sent, tx;
  int         vectors = 0;
  int         errors = 0;

  usart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .tx_led    (tx_led),
    .bytetosend(bytetosend),
    .send      (send),
    .sent      (sent),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  // Called on a negedge; returns on the negedge right after the accept edge.
  task automatic pulse(input logic [7:0] b);
    bytetosend = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    bytetosend = 8'hXX;
  endtask

  // Checks tx every clock of a frame, samples mid-bit like a receiver, and
  // optionally pulses send (with another byte) at clock inj_at of the frame.
  task automatic check_frame(input string name, input logic [7:0] d, input int inj_at,
                             input logic [7:0] inj_b, output logic par_seen);
    logic [10:0] w;
    logic [7:0]  rx;
    bit          tx_bad, st_bad;
    tx_bad = 0;
    st_bad = 0;
    rx = 8'h00;
    par_seen = 1'bx;
`ifdef USART_PARITY_EN
    w = {1'b1, ^d, d, 1'b0};
`else
    w = {1'b1, 1'b1, d, 1'b0};
`endif
    vectors += 2;
    for (int k = 0; k < FRAME; k++) begin
      if (k == inj_at) begin
        bytetosend = inj_b;
        send = 1'b1;
      end
      if (k == inj_at + 1) send = 1'b0;
      if (!tx_bad && tx !== w[k / DIV]) begin
        tx_bad = 1;
        errors++;
        $display("FAIL %s tx clk %0d: got %b want %b", name, k, tx, w[k / DIV]);
      end
      if (!st_bad && (sent !== 1'b0 || tx_led !== 1'b1)) begin
        st_bad = 1;
        errors++;
        $display("FAIL %s busy flags clk %0d: sent=%b led=%b want 0/1", name, k, sent, tx_led);
      end
      if ((k % DIV) == DIV / 2 && k / DIV >= 1 && k / DIV <= 8) rx[k / DIV - 1] = tx;
      if ((k % DIV) == DIV / 2 && k / DIV == 9) par_seen = tx;
      @(negedge clk);
    end
    vectors++;
    if (rx !== d) begin
      errors++;
      $display("FAIL %s decode: got %h want %h", name, rx, d);
    end
    vectors++;
    if (sent !== 1'b1 || tx !== 1'b1 || tx_led !== 1'b0) begin
      errors++;
      $display("FAIL %s frame end: sent=%b tx=%b led=%b want 1/1/0", name, sent, tx, tx_led);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sent !== 1'b1 && n < 20 * DIV) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sent !== 1'b1) begin
      errors++;
      $display("FAIL %s wait idle: sent=%b want 1 (timeout)", name, sent);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || sent !== 1'b1 || tx_led !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: tx=%b sent=%b led=%b want 1/1/0", tx, sent, tx_led);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || sent !== 1'b1 || tx_led !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tx=%b sent=%b led=%b want 1/1/0", tx, sent, tx_led);
    end
  endtask

  task automatic test_single;
    logic p;
    pulse(8'h41);  // expect 0,1,0,0,0,0,0,1,0,1
    check_frame("single_41", 8'h41, -1, 8'h00, p);
  endtask

  task automatic test_busy_ignore;
    logic p;
    bit   bad;
    bad = 0;
    pulse(8'h55);
    check_frame("busy_55", 8'h55, 300, 8'hFF, p);
    vectors++;
    for (int k = 0; k < 2 * DIV; k++) begin
      if (!bad && (sent !== 1'b1 || tx !== 1'b1)) begin
        bad = 1;
        errors++;
        $display("FAIL busy_no_second clk %0d: sent=%b tx=%b want 1/1", k, sent, tx);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic p;
    for (int i = 0; i < 8; i++) begin
      wait_idle("b2b");
      pulse(8'(i));
      check_frame($sformatf("b2b_%0d", i), 8'(i), -1, 8'h00, p);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic p;
    pulse(8'hA5);
    repeat (4 * DIV + 50) @(negedge clk);  // inside data bit 3 (= 0)
    vectors++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: tx=%b want 0", tx);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || sent !== 1'b1 || tx_led !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: tx=%b sent=%b led=%b want 1/1/0", tx, sent, tx_led);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || sent !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: tx=%b sent=%b want 1/1", tx, sent);
    end
    pulse(8'h3C);
    check_frame("midrst_3C", 8'h3C, -1, 8'h00, p);
  endtask

`ifdef USART_PARITY_EN
  task automatic test_parity;
    logic p;
    pulse(8'h07);
    check_frame("par_07", 8'h07, -1, 8'h00, p);
    vectors++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL par_07 bit: got %b want 1", p);
    end
    pulse(8'h03);
    check_frame("par_03", 8'h03, -1, 8'h00, p);
    vectors++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL par_03 bit: got %b want 0", p);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef USART_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
